// File: rtl/skid_fifo_pkg.sv
// Shared constants, types and helpers for the skid_fifo elastic buffer.
//   SKID_DWIDTH_DEF / SKID_DEPTH_DEF : default data width and entry count
//   op_e                             : storage operation for one cycle
//   ptr_w(depth)                     : pointer width for a given depth
package skid_fifo_pkg;

  localparam int unsigned SKID_DWIDTH_DEF = 8;
  localparam int unsigned SKID_DEPTH_DEF  = 4;

  // Encoding is {pop, write} so it can be built directly from the two strobes.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/skid_fifo_if.sv
// Valid/ready stream bundle for skid_fifo, including flush and occupancy.
//   i_flush, i_data, i_valid : producer side (into the buffer)
//   o_ready                  : ready back to producer
//   o_data, o_valid          : consumer side (out of the buffer)
//   i_ready                  : ready from consumer
//   o_count                  : occupancy, $clog2(DEPTH+1) bits
// Modports: master = environment driving the buffer, slave = the buffer.
interface skid_fifo_if
  import skid_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = SKID_DWIDTH_DEF,
  parameter int unsigned DEPTH  = SKID_DEPTH_DEF
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              i_flush;
  logic [DWIDTH-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [DWIDTH-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic [CNT_W-1:0]  o_count;

  modport master (
    output i_flush, i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_count
  );

  modport slave (
    input  i_flush, i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_count
  );

endinterface

// File: rtl/skid_fifo_mem.sv
// DEPTH x DWIDTH register array for skid_fifo.
//   clk, rstn      : clock, async active-low reset (clears all entries)
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous read port
module skid_fifo_mem #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/skid_fifo.sv
// skid_fifo: register-based elastic buffer with valid/ready on both sides.
// o_ready and o_count are registered; with the default build there is no
// combinational path from producer to consumer. Flush empties the buffer on
// the next edge and wins over a coincident push.
// Optional feature macro: SKID_FIFO_BYPASS_EN -- when empty, input passes
// straight to the output; if the consumer takes it that cycle it is never
// stored.
// Ports:
//   clk  : clock, rising edge
//   rstn : async active-low reset
//   bus  : skid_fifo_if.slave (flush, upstream/downstream handshake, count)
module skid_fifo
  import skid_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = SKID_DWIDTH_DEF,
  parameter int unsigned DEPTH  = SKID_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  skid_fifo_if.slave bus
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              ready_q, ready_next;
  logic              empty;
  logic              push;
  logic              pop;
  logic              mem_we;
  logic              mem_pop;
  logic [DWIDTH-1:0] mem_rdata;
  op_e               op;

  assign empty = (count == '0);
  assign push  = bus.i_valid && ready_q;

`ifdef SKID_FIFO_BYPASS_EN
  logic pass;

  // Gated by ready_q so nothing is offered downstream in the first cycle
  // after reset, before the producer side can handshake.
  assign pass        = empty && bus.i_valid && ready_q && bus.i_ready;
  assign bus.o_valid = empty ? (bus.i_valid && ready_q) : 1'b1;
  assign bus.o_data  = empty ? bus.i_data : mem_rdata;
  assign mem_we      = push && !pass && !bus.i_flush;
`else
  assign bus.o_valid = !empty;
  assign bus.o_data  = mem_rdata;
  assign mem_we      = push && !bus.i_flush;
`endif

  assign pop     = bus.o_valid && bus.i_ready;
  // Only a pop out of storage moves the read side; a bypassed word does not.
  assign mem_pop = pop && !empty;

  always_comb begin
    op = op_e'({mem_pop, mem_we});
  end

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (bus.i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      case (op)
        OP_PUSH: begin
          wr_ptr_next = wr_ptr + PTR_W'(1);
          count_next  = count + CNT_W'(1);
        end
        OP_POP: begin
          rd_ptr_next = rd_ptr + PTR_W'(1);
          count_next  = count - CNT_W'(1);
        end
        OP_BOTH: begin
          wr_ptr_next = wr_ptr + PTR_W'(1);
          rd_ptr_next = rd_ptr + PTR_W'(1);
        end
        default: ;
      endcase
    end
    ready_next = (count_next < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_next;
      rd_ptr  <= rd_ptr_next;
      count   <= count_next;
      ready_q <= ready_next;
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_count = count;

  skid_fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (bus.i_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_skid_fifo.sv
// Directed self-checking bench for skid_fifo (DWIDTH=8, DEPTH=4).
// Expectations follow SKID_FIFO_BYPASS_EN when it is defined for the build.
module tb_skid_fifo;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  skid_fifo_if #(.DWIDTH(8), .DEPTH(4)) bus ();

  skid_fifo #(.DWIDTH(8), .DEPTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    rstn        = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    #12;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.o_ready); end
    checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.o_count); end
    checks++; if (bus.o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.o_data); end
    tick;
    rstn = 1'b1;
    settle;
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL release_ready_pre got %b exp 0", bus.o_ready); end
    tick;
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL release_ready_post got %b exp 1", bus.o_ready); end
  endtask

  // Pushes n consecutive words starting at base with i_ready held high.
  task automatic stream(input logic [7:0] base, input int n, input string tag);
    bus.i_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = base + 8'(k);
`ifdef SKID_FIFO_BYPASS_EN
      settle;
      checks++; if (bus.o_data !== base + 8'(k)) begin errors++; $display("FAIL %s_bypass_data[%0d] got %h exp %h", tag, k, bus.o_data, base + 8'(k)); end
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL %s_bypass_valid[%0d] got %b exp 1", tag, k, bus.o_valid); end
      tick;
      checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL %s_count[%0d] got %0d exp 0", tag, k, bus.o_count); end
`else
      tick;
      checks++; if (bus.o_data !== base + 8'(k)) begin errors++; $display("FAIL %s_data[%0d] got %h exp %h", tag, k, bus.o_data, base + 8'(k)); end
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL %s_valid[%0d] got %b exp 1", tag, k, bus.o_valid); end
      checks++; if (bus.o_count !== 3'd1) begin errors++; $display("FAIL %s_count[%0d] got %0d exp 1", tag, k, bus.o_count); end
`endif
    end
    bus.i_valid = 1'b0;
    tick;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL %s_end_valid got %b exp 0", tag, bus.o_valid); end
    checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL %s_end_count got %0d exp 0", tag, bus.o_count); end
  endtask

  task automatic test_stream;
    stream(8'h01, 16, "stream");
  endtask

  task automatic test_fill_drain;
    bus.i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 8'hA0 + 8'(k);
      tick;
      checks++; if (bus.o_count !== 3'(k + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", k, bus.o_count, k + 1); end
    end
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.o_ready); end
    bus.i_data = 8'hA4;
    tick;
    tick;
    checks++; if (bus.o_count !== 3'd4) begin errors++; $display("FAIL full_hold_count got %0d exp 4", bus.o_count); end
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready got %b exp 0", bus.o_ready); end
    checks++; if (bus.o_data !== 8'hA0) begin errors++; $display("FAIL full_hold_data got %h exp a0", bus.o_data); end
    // One-cycle drain: A0 leaves, ready returns on the following cycle.
    bus.i_ready = 1'b1;
    settle;
    checks++; if (bus.o_data !== 8'hA0) begin errors++; $display("FAIL drain_first got %h exp a0", bus.o_data); end
    tick;
    bus.i_ready = 1'b0;
    settle;
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", bus.o_ready); end
    checks++; if (bus.o_count !== 3'd3) begin errors++; $display("FAIL drain_count got %0d exp 3", bus.o_count); end
    checks++; if (bus.o_data !== 8'hA1) begin errors++; $display("FAIL drain_head got %h exp a1", bus.o_data); end
    tick;
    bus.i_valid = 1'b0;
    checks++; if (bus.o_count !== 3'd4) begin errors++; $display("FAIL refill_count got %0d exp 4", bus.o_count); end
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL refill_ready got %b exp 0", bus.o_ready); end
    bus.i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      settle;
      checks++; if (bus.o_data !== 8'hA0 + 8'(k)) begin errors++; $display("FAIL drain_order[%0d] got %h exp %h", k, bus.o_data, 8'hA0 + 8'(k)); end
      tick;
    end
    checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL drain_empty_count got %0d exp 0", bus.o_count); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %b exp 0", bus.o_valid); end
  endtask

  task automatic test_back_to_back;
    bus.i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 8'h30 + 8'(k);
      tick;
    end
    checks++; if (bus.o_count !== 3'd2) begin errors++; $display("FAIL b2b_pre_count got %0d exp 2", bus.o_count); end
    bus.i_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.i_data = 8'h32 + 8'(j);
      settle;
      checks++; if (bus.o_data !== 8'h30 + 8'(j)) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", j, bus.o_data, 8'h30 + 8'(j)); end
      tick;
      checks++; if (bus.o_count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 2", j, bus.o_count); end
    end
    bus.i_valid = 1'b0;
    for (int j = 20; j < 22; j++) begin
      settle;
      checks++; if (bus.o_data !== 8'h30 + 8'(j)) begin errors++; $display("FAIL b2b_tail[%0d] got %h exp %h", j, bus.o_data, 8'h30 + 8'(j)); end
      tick;
    end
    checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL b2b_end_count got %0d exp 0", bus.o_count); end
  endtask

  task automatic test_flush;
    bus.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 8'hD0 + 8'(k);
      tick;
    end
    checks++; if (bus.o_count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", bus.o_count); end
    bus.i_data  = 8'h55;
    bus.i_flush = 1'b1;
    tick;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    settle;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus.o_valid); end
    checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", bus.o_count); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", bus.o_ready); end
    bus.i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL flush_no55[%0d] got valid %b data %h exp valid 0", k, bus.o_valid, bus.o_data); end
    end
  endtask

  task automatic test_async_reset;
    bus.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 8'hE0 + 8'(k);
      tick;
    end
    bus.i_valid = 1'b0;
    checks++; if (bus.o_count !== 3'd3) begin errors++; $display("FAIL areset_pre_count got %0d exp 3", bus.o_count); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL areset_ready got %b exp 0", bus.o_ready); end
    checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", bus.o_count); end
    tick;
    tick;
    rstn = 1'b1;
    settle;
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL areset_release_pre got %b exp 0", bus.o_ready); end
    tick;
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL areset_release_post got %b exp 1", bus.o_ready); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL areset_release_valid got %b exp 0", bus.o_valid); end
    stream(8'hF0, 3, "resume");
  endtask

  task automatic test_bypass;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h7E;
    settle;
`ifdef SKID_FIFO_BYPASS_EN
    checks++; if (bus.o_data !== 8'h7E) begin errors++; $display("FAIL bypass_data got %h exp 7e", bus.o_data); end
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got %b exp 1", bus.o_valid); end
    tick;
    bus.i_valid = 1'b0;
    settle;
    checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL bypass_count got %0d exp 0", bus.o_count); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL bypass_after_valid got %b exp 0", bus.o_valid); end
`else
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL nobypass_valid got %b exp 0", bus.o_valid); end
    tick;
    bus.i_valid = 1'b0;
    settle;
    checks++; if (bus.o_data !== 8'h7E) begin errors++; $display("FAIL nobypass_data got %h exp 7e", bus.o_data); end
    checks++; if (bus.o_count !== 3'd1) begin errors++; $display("FAIL nobypass_count got %0d exp 1", bus.o_count); end
    tick;
    checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL nobypass_drain got %0d exp 0", bus.o_count); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_stream;
    test_fill_drain;
    test_back_to_back;
    test_flush;
    test_async_reset;
    test_bypass;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
